// File: rtl/uart_debug_fifo.sv
// rtl/uart_debug_fifo.sv - debug word FIFO with paced single-cycle replay toward the UART serializer
module uart_debug_fifo #(
    parameter int DATA_BYTES   = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int HOLDOFF_CLKS = 5000,
    localparam int W           = DATA_BYTES * 8,
    localparam int L           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_data_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_drop_clr,
    output logic         o_data_valid,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full,
    output logic [L-1:0] o_level,
    output logic [15:0]  o_drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(HOLDOFF_CLKS);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF_CLKS - 1);
    localparam logic [L-1:0]  DEPTH_LVL  = L'(FIFO_DEPTH);

    typedef enum logic {
        READY = 1'b0,
        HOLD  = 1'b1
    } pacer_t;

    pacer_t        state;
    logic [CW-1:0] holdoff;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W-1:0]  mem [FIFO_DEPTH];

    logic          pop;
    logic          push;
    logic          reject;
    logic [L-1:0]  level_next;

    // Pops only see words already stored, so a push into an empty FIFO waits a cycle.
    assign pop    = (state == READY) && !o_empty;
    assign push   = i_data_valid && (!o_full || pop);
    assign reject = i_data_valid && !push;

    always_comb begin
        level_next = o_level;
        case ({push, pop})
            2'b10:   level_next = o_level + L'(1);
            2'b01:   level_next = o_level - L'(1);
            default: level_next = o_level;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            o_level <= level_next;
            o_empty <= (level_next == '0);
            o_full  <= (level_next == DEPTH_LVL);
        end
    end

    // A clear coinciding with a rejected write leaves exactly that one drop counted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_drop_cnt <= '0;
        end else if (i_drop_clr) begin
            o_drop_cnt <= reject ? 16'd1 : 16'd0;
        end else if (reject && (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= READY;
            holdoff      <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
        end else begin
            o_data_valid <= 1'b0;
            case (state)
                READY: begin
                    if (pop) begin
                        o_data       <= mem[rd_ptr];
                        o_data_valid <= 1'b1;
                        holdoff      <= HOLD_LOAD;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    holdoff <= holdoff - CW'(1);
                    if (holdoff == CW'(1)) begin
                        state <= READY;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_debug_fifo.sv
// tb/tb_uart_debug_fifo.sv - randomized/directed bench for uart_debug_fifo against a queue-based model
module tb_uart_debug_fifo;

    localparam int DB = 2;
    localparam int D  = 4;
    localparam int H  = 8;
    localparam int W  = DB * 8;
    localparam int L  = $clog2(D) + 1;

    logic         i_clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_data_valid = 1'b0;
    logic [W-1:0] i_data = '0;
    logic         i_drop_clr = 1'b0;
    logic         o_data_valid;
    logic [W-1:0] o_data;
    logic         o_empty;
    logic         o_full;
    logic [L-1:0] o_level;
    logic [15:0]  o_drop_cnt;

    uart_debug_fifo #(.DATA_BYTES(DB), .FIFO_DEPTH(D), .HOLDOFF_CLKS(H)) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_data_valid(i_data_valid),
        .i_data(i_data),
        .i_drop_clr(i_drop_clr),
        .o_data_valid(o_data_valid),
        .o_data(o_data),
        .o_empty(o_empty),
        .o_full(o_full),
        .o_level(o_level),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a word queue plus the earliest edge at which the next issue may occur.
    logic [W-1:0] mq[$];
    int           cyc = 0;
    int           ready_at = 0;
    int           reject_total = 0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_data = '0;
    int           exp_level = 0;
    int           exp_drop = 0;
    logic [W-1:0] accepted[$];
    logic [W-1:0] strobe_dat[$];
    int           strobe_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ready_at  = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_level = 0;
        exp_drop  = 0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic clr);
        int  sz;
        bit  pop;
        bit  push;
        bit  rej;
        cyc++;
        sz  = mq.size();
        pop = (cyc >= ready_at) && (sz > 0);
        exp_valid = pop;
        if (pop) begin
            exp_data = mq.pop_front();
            ready_at = cyc + H;
        end
        push = v && ((sz < D) || pop);
        if (push) begin
            mq.push_back(d);
            accepted.push_back(d);
        end
        rej = v && !push;
        if (rej) reject_total++;
        if (clr) exp_drop = rej ? 1 : 0;
        else if (rej && exp_drop < 16'hFFFF) exp_drop++;
        exp_level = mq.size();
    endtask

    task automatic compare_all();
        check("data_valid", 32'(o_data_valid), 32'(exp_valid));
        check("data", 32'(o_data), 32'(exp_data));
        check("level", 32'(o_level), 32'(exp_level));
        check("empty", 32'(o_empty), 32'(exp_level == 0));
        check("full", 32'(o_full), 32'(exp_level == D));
        check("drop_cnt", 32'(o_drop_cnt), 32'(exp_drop));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(o_data_valid), 0);
        check({tag, "_data"}, 32'(o_data), 0);
        check({tag, "_level"}, 32'(o_level), 0);
        check({tag, "_empty"}, 32'(o_empty), 1);
        check({tag, "_full"}, 32'(o_full), 0);
        check({tag, "_drop"}, 32'(o_drop_cnt), 0);
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic clr, input bit chk);
        i_data_valid = v;
        i_data       = d;
        i_drop_clr   = clr;
        @(posedge i_clk);
        model_edge(v, d, clr);
        @(negedge i_clk);
        if (o_data_valid) begin
            strobe_cyc.push_back(cyc);
            strobe_dat.push_back(o_data);
        end
        if (chk) compare_all();
    endtask

    task automatic drain();
        int guard = 0;
        while ((mq.size() > 0 || cyc + 1 < ready_at) && guard < 400) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            guard++;
        end
        check("drain_bound", 32'(guard < 400), 1);
    endtask

    task automatic clear_logs();
        accepted.delete();
        strobe_dat.delete();
        strobe_cyc.delete();
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(strobe_dat.size()), 32'(accepted.size()));
        for (int i = 0; i < accepted.size() && i < strobe_dat.size(); i++)
            check({tag, "_word"}, 32'(strobe_dat[i]), 32'(accepted[i]));
    endtask

    initial begin
        int g;
        int wn;

        // Power-on reset
        #12;
        check_reset_values("por");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Single word: level 1, then strobe with 0xA55A and level 0
        clear_logs();
        cycle(1'b1, 16'hA55A, 1'b0, 1'b1);
        check("single_level1", 32'(o_level), 1);
        check("single_novalid", 32'(o_data_valid), 0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("single_valid", 32'(o_data_valid), 1);
        check("single_data", 32'(o_data), 32'hA55A);
        check("single_level0", 32'(o_level), 0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("single_pulse", 32'(o_data_valid), 0);
        drain();

        // Burst of four: exact spacing of H, in order
        clear_logs();
        for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0, 1'b1);
        drain();
        check_stream("burst");
        check("burst_strobes", 32'(strobe_cyc.size()), 4);
        for (int i = 1; i < strobe_cyc.size(); i++)
            check("burst_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), H);

        // Overflow: seven back-to-back writes
        clear_logs();
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'h0010 + W'(i), 1'b0, 1'b1);
        check("ovf_drop", 32'(o_drop_cnt), 2);
        drain();
        check_stream("ovf");

        // Reset mid-HOLD with three words queued
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0100 + W'(i), 1'b0, 1'b1);
        check("pre_rst_level", 32'(o_level), 3);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_reset_values("rst_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check_reset_values("rst_held");
        end
        i_reset_n = 1'b1;
        model_reset();
        clear_logs();
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("post_rst_strobes", 32'(strobe_dat.size()), 0);

        // Wrap-around with random interleaving, no rejections
        clear_logs();
        wn = 0;
        g  = 0;
        while (wn < 3 * D && g < 3000) begin
            if ($urandom_range(0, 2) != 0 && mq.size() < D) begin
                cycle(1'b1, W'($urandom), 1'b0, 1'b1);
                wn++;
            end else begin
                cycle(1'b0, '0, 1'b0, 1'b1);
            end
            g++;
        end
        check("wrap_bound", 32'(wn), 3 * D);
        drain();
        check_stream("wrap");

        // Saturation: hold writes high until 0x10005 rejections have occurred
        g = 0;
        while (reject_total < 32'h10005 && g < 90000) begin
            cycle(1'b1, W'($urandom), 1'b0, 1'b0);
            g++;
        end
        check("sat_bound", 32'(reject_total), 32'h10005);
        compare_all();
        check("sat_value", 32'(o_drop_cnt), 32'hFFFF);
        g = 0;
        while (cyc + 1 >= ready_at && g < 20) begin
            cycle(1'b1, W'($urandom), 1'b0, 1'b1);
            g++;
        end
        cycle(1'b1, W'($urandom), 1'b1, 1'b1);
        check("clr_with_reject", 32'(o_drop_cnt), 1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("clr_alone", 32'(o_drop_cnt), 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
